// File: rtl/shift_register_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl_pkg
// Brief    : Shared state encoding and default widths for the shift controller.
// Revision : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_register_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_ctrl_if
// Brief    : Requester-side bundle: transmit handshake, divider, abort, result.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_register_ctrl_if
    import shift_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DIV_W  = DEFAULT_DIV_W
);

    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_valid;
    logic              o_tx_ready;
    logic [DIV_W-1:0]  i_div;
    logic              i_abort;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              o_busy;

    modport slave (
        input  i_tx_data, i_tx_valid, i_div, i_abort,
        output o_tx_ready, o_rx_data, o_rx_valid, o_busy
    );

    modport master (
        output i_tx_data, i_tx_valid, i_div, i_abort,
        input  o_tx_ready, o_rx_data, o_rx_valid, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/shift_register_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : shift_tick_gen
// Brief    : Clearable divider producing a one-cycle tick every period+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module shift_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    assign tick = enable && (div_cnt == period);

    // Wrapping on the tick keeps an all-ones period from ever overflowing.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || clear) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_register_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_ctrl
// Brief    : Load / paced-shift / capture sequencer for the serial shift register.
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DIV_W  = DEFAULT_DIV_W
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    shift_register_ctrl_if.slave bus,
    output logic [DATA_W-1:0]    o_ld_data,
    output logic                 o_load,
    output logic                 o_shift,
    input  logic [DATA_W-1:0]    i_sr_parallel
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_hold;
    logic              tick;
    logic              accept;

    assign accept = (state == IDLE) && bus.i_tx_valid;

    shift_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .clear  (state != SHIFT),
        .enable (state == SHIFT),
        .period (div_q),
        .tick   (tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        o_load         = 1'b0;
        o_shift        = 1'b0;
        bus.o_tx_ready = 1'b0;
        bus.o_busy     = 1'b1;
        bus.o_rx_valid = 1'b0;
        // The datapath applies the last shift on the edge that enters DONE,
        // so its parallel word is only correct during DONE itself.
        bus.o_rx_data  = (state == DONE) ? i_sr_parallel : rx_hold;
        case (state)
            IDLE: begin
                bus.o_tx_ready = 1'b1;
                bus.o_busy     = 1'b0;
                if (bus.i_tx_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                o_load    = 1'b1;
                state_nxt = bus.i_abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                o_shift = tick;
                if (bus.i_abort) begin
                    state_nxt = IDLE;
                end else if (tick && (bit_cnt == LAST_BIT)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.o_rx_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_ld_data <= '0;
            div_q     <= '0;
            bit_cnt   <= '0;
            rx_hold   <= '0;
        end else begin
            if (accept) begin
                o_ld_data <= bus.i_tx_data;
                div_q     <= bus.i_div;
            end
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if ((state == SHIFT) && tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == DONE) begin
                rx_hold <= i_sr_parallel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_register_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register_ctrl
// Brief    : Directed bench with a rotating shift-register model on the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_ctrl;
    import shift_ctrl_pkg::*;

    logic       i_clk  = 1'b0;
    logic       i_rstn = 1'b0;
    logic [7:0] o_ld_data;
    logic       o_load;
    logic       o_shift;
    logic [7:0] sr     = 8'h00;

    always #5 i_clk = ~i_clk;

    shift_register_ctrl_if #(.DATA_W(8), .DIV_W(8)) bus ();

    shift_register_ctrl #(
        .DATA_W (8),
        .DIV_W  (8)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .bus           (bus),
        .o_ld_data     (o_ld_data),
        .o_load        (o_load),
        .o_shift       (o_shift),
        .i_sr_parallel (sr)
    );

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   overlap  = 0;
    logic rdy_prev = 1'b1;
    int   acc_q[$], load_q[$], shift_q[$], rv_q[$], rxd_q[$], rdy_q[$];

    // Serial out looped to serial in: eight shifts return the loaded word.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (i_rstn && bus.i_tx_valid && bus.o_tx_ready) acc_q.push_back(cyc + 1);
        if (o_load) sr <= o_ld_data;
        else if (o_shift) sr <= {sr[6:0], sr[7]};
    end

    always @(negedge i_clk) begin
        if (o_load) load_q.push_back(cyc + 1);
        if (o_shift) shift_q.push_back(cyc + 1);
        if (o_load && o_shift) overlap <= overlap + 1;
        if (bus.o_rx_valid) begin
            rv_q.push_back(cyc + 1);
            rxd_q.push_back(int'(bus.o_rx_data));
        end
        if (bus.o_tx_ready && !rdy_prev) rdy_q.push_back(cyc + 1);
        rdy_prev <= bus.o_tx_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete(); load_q.delete(); shift_q.delete();
        rv_q.delete(); rxd_q.delete(); rdy_q.delete();
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0:       return acc_q.size();
            1:       return shift_q.size();
            default: return rv_q.size();
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int n, input int budget);
        int sz;
        sz = qsize(which);
        for (int i = 0; i < budget && sz < n; i++) begin
            tick();
            sz = qsize(which);
        end
        if (sz < n) chk({tag, " timeout"}, sz, n);
    endtask

    task automatic check_xfer(input string tag, input int idx, input int d, input int data);
        int t;
        t = qget(acc_q, idx);
        chk({tag, " load"}, qget(load_q, idx), t + 1);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s shift%0d", tag, k), qget(shift_q, idx * 8 + k),
                t + 2 + d + k * (d + 1));
        chk({tag, " rx_valid"}, qget(rv_q, idx), t + 2 + 8 * (d + 1));
        chk({tag, " rx_data"}, qget(rxd_q, idx), data);
        chk({tag, " ready"}, qget(rdy_q, idx), t + 3 + 8 * (d + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ready"}, bus.o_tx_ready, 1);
        chk({tag, " busy"}, bus.o_busy, 0);
        chk({tag, " load"}, o_load, 0);
        chk({tag, " shift"}, o_shift, 0);
        chk({tag, " rx_valid"}, bus.o_rx_valid, 0);
        chk({tag, " ld_data"}, o_ld_data, 0);
        chk({tag, " rx_data"}, bus.o_rx_data, 0);
    endtask

    initial begin
        int rel;
        bus.i_tx_data  = 8'h00;
        bus.i_tx_valid = 1'b0;
        bus.i_div      = 8'h00;
        bus.i_abort    = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        i_rstn = 1'b1;
        tick();

        // div=0, A5: shift every cycle
        clear_q();
        bus.i_tx_data = 8'hA5; bus.i_div = 8'd0; bus.i_tx_valid = 1'b1;
        wait_for("a5 acc", 0, 1, 5);
        bus.i_tx_valid = 1'b0;
        wait_for("a5 rv", 2, 1, 40);
        tick(); tick();
        check_xfer("a5", 0, 0, 8'hA5);
        chk("a5 nshift", shift_q.size(), 8);

        // div=3, 3C
        clear_q();
        bus.i_tx_data = 8'h3C; bus.i_div = 8'd3; bus.i_tx_valid = 1'b1;
        wait_for("3c acc", 0, 1, 5);
        bus.i_tx_valid = 1'b0;
        wait_for("3c rv", 2, 1, 100);
        tick(); tick();
        check_xfer("3c", 0, 3, 8'h3C);
        chk("3c nshift", shift_q.size(), 8);

        // abort right after the third shift
        clear_q();
        bus.i_tx_data = 8'hC3; bus.i_div = 8'd1; bus.i_tx_valid = 1'b1;
        wait_for("ab acc", 0, 1, 5);
        bus.i_tx_valid = 1'b0;
        wait_for("ab shift3", 1, 3, 40);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        chk("ab busy", bus.o_busy, 0);
        chk("ab ready", bus.o_tx_ready, 1);
        chk("ab shift", o_shift, 0);
        repeat (40) tick();
        chk("ab nshift", shift_q.size(), 3);
        chk("ab nrv", rv_q.size(), 0);
        chk("ab nload", load_q.size(), 1);
        chk("ab rx_data kept", bus.o_rx_data, 8'h3C);

        // reset mid-SHIFT, then an immediate new transfer
        clear_q();
        bus.i_tx_data = 8'h5A; bus.i_div = 8'd2; bus.i_tx_valid = 1'b1;
        wait_for("rs acc", 0, 1, 5);
        bus.i_tx_valid = 1'b0;
        wait_for("rs shift2", 1, 2, 40);
        i_rstn = 1'b0;
        tick();
        check_reset_outputs("midrst");
        i_rstn = 1'b1;
        clear_q();
        rel = cyc;
        bus.i_tx_data = 8'h96; bus.i_div = 8'd0; bus.i_tx_valid = 1'b1;
        wait_for("rs2 acc", 0, 1, 5);
        bus.i_tx_valid = 1'b0;
        chk("rs2 acc time", qget(acc_q, 0), rel + 1);
        wait_for("rs2 rv", 2, 1, 40);
        tick(); tick();
        check_xfer("rs2", 0, 0, 8'h96);

        // back-to-back with valid held; div change lands only on the second
        clear_q();
        bus.i_tx_data = 8'h01; bus.i_div = 8'd0; bus.i_tx_valid = 1'b1;
        wait_for("b2b acc0", 0, 1, 5);
        bus.i_tx_data = 8'h80; bus.i_div = 8'd2;
        wait_for("b2b acc1", 0, 2, 40);
        bus.i_tx_valid = 1'b0;
        wait_for("b2b rv", 2, 2, 60);
        tick(); tick();
        check_xfer("b2b0", 0, 0, 8'h01);
        check_xfer("b2b1", 1, 2, 8'h80);
        chk("b2b accept at ready", qget(acc_q, 1), qget(rdy_q, 0));

        // maximum divider; stray valid pulse during SHIFT
        clear_q();
        bus.i_tx_data = 8'hE7; bus.i_div = 8'hFF; bus.i_tx_valid = 1'b1;
        wait_for("ff acc", 0, 1, 5);
        bus.i_tx_valid = 1'b0;
        repeat (20) tick();
        bus.i_tx_data = 8'h11; bus.i_tx_valid = 1'b1;
        tick();
        bus.i_tx_valid = 1'b0;
        wait_for("ff rv", 2, 1, 2200);
        tick(); tick();
        check_xfer("ff", 0, 255, 8'hE7);
        chk("ff nacc", acc_q.size(), 1);
        chk("ff nshift", shift_q.size(), 8);
        chk("ff ld_data", o_ld_data, 8'hE7);
        chk("load/shift overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
